// File: rtl/matmul_sequencer.sv
// Tile-command sequencer for an HxH multiply array; first LOAD_A issues two cycles after the start edge.
// Each command holds until cmd_ready_i; defining MATMUL_SEQ_PERF_EN builds the job cycle counter on cycles_o.
module matmul_sequencer #(
  parameter int ARRAY_HEIGHT = 16
) (
  input  logic        pclk,
  input  logic        preset_n,
  input  logic        start_i,
  input  logic [15:0] matrix_a_addr_i,
  input  logic [15:0] matrix_b_addr_i,
  input  logic [15:0] matrix_c_addr_i,
  input  logic [15:0] m_i,
  input  logic [15:0] n_i,
  input  logic [15:0] p_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [1:0]  cmd_op_o,
  output logic [15:0] cmd_addr_o,
  output logic [15:0] cmd_stride_o,
  output logic        acc_clear_o,
  input  logic        array_busy_i,
  output logic        busy_o,
  output logic        end_o,
  output logic [31:0] cycles_o
);

  localparam int              LG     = $clog2(ARRAY_HEIGHT);
  localparam logic [15:0]     H16    = 16'(ARRAY_HEIGHT);
  localparam logic [LG-1:0]   R_LAST = LG'(ARRAY_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD_A, S_LOAD_B, S_DRAIN, S_STORE, S_DONE
  } state_t;

  state_t        r_state, w_next;
  logic          r_start_q, r_zero_wait;
  logic [15:0]   r_n, r_p, r_hn, r_hp, r_mt, r_pt;
  logic [15:0]   r_ti, r_tj, r_k;
  logic [LG-1:0] r_r;
  logic [15:0]   r_b_base, r_a_tile, r_c_tile, r_tj_off;
  logic [15:0]   r_a_ptr, r_b_ptr, r_c_ptr;

  logic          w_start_edge, w_zero_dim, w_accept;
  logic          w_k_last, w_r_last, w_tj_last, w_ti_last;
  logic [16:0]   w_m_round, w_p_round;

  assign w_start_edge = start_i & ~r_start_q;
  assign w_zero_dim   = (m_i == 16'd0) | (n_i == 16'd0) | (p_i == 16'd0);
  assign w_accept     = cmd_valid_o & cmd_ready_i;
  assign w_k_last     = (r_k == r_n - 16'd1);
  assign w_r_last     = (r_r == R_LAST);
  assign w_tj_last    = (r_tj == r_pt - 16'd1);
  assign w_ti_last    = (r_ti == r_mt - 16'd1);
  // Partial edge tiles are issued as whole tiles; the memory side masks them.
  assign w_m_round    = {1'b0, m_i} + 17'(ARRAY_HEIGHT - 1);
  assign w_p_round    = {1'b0, p_i} + 17'(ARRAY_HEIGHT - 1);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start_edge) w_next = w_zero_dim ? S_DONE : S_CLEAR;
      S_CLEAR:  w_next = S_LOAD_A;
      S_LOAD_A: if (w_accept) w_next = S_LOAD_B;
      S_LOAD_B: if (w_accept) w_next = w_k_last ? S_DRAIN : S_LOAD_A;
      S_DRAIN:  if (!array_busy_i) w_next = S_STORE;
      S_STORE:  if (w_accept && w_r_last) w_next = (w_ti_last && w_tj_last) ? S_DONE : S_CLEAR;
      S_DONE:   if (!r_zero_wait) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid_o  = 1'b0;
    cmd_op_o     = 2'd0;
    cmd_addr_o   = r_a_ptr;
    cmd_stride_o = r_n;
    acc_clear_o  = 1'b0;
    busy_o       = (r_state != S_IDLE);
    end_o        = 1'b0;
    case (r_state)
      S_CLEAR:  acc_clear_o = 1'b1;
      S_LOAD_A: begin
        cmd_valid_o  = 1'b1;
        cmd_op_o     = 2'd0;
        cmd_addr_o   = r_a_ptr;
        cmd_stride_o = r_n;
      end
      S_LOAD_B: begin
        cmd_valid_o  = 1'b1;
        cmd_op_o     = 2'd1;
        cmd_addr_o   = r_b_ptr;
        cmd_stride_o = 16'd1;
      end
      S_STORE: begin
        cmd_valid_o  = 1'b1;
        cmd_op_o     = 2'd2;
        cmd_addr_o   = r_c_ptr;
        cmd_stride_o = 16'd1;
      end
      S_DONE:   end_o = ~r_zero_wait;
      default:  ;
    endcase
  end

  // A zero-size job spends one extra DONE cycle so its end pulse lands where a real job's first LOAD_A would.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_start_q   <= 1'b0;
      r_zero_wait <= 1'b0;
      r_n         <= '0;
      r_p         <= '0;
      r_hn        <= '0;
      r_hp        <= '0;
      r_mt        <= '0;
      r_pt        <= '0;
      r_ti        <= '0;
      r_tj        <= '0;
      r_k         <= '0;
      r_r         <= '0;
      r_b_base    <= '0;
      r_a_tile    <= '0;
      r_c_tile    <= '0;
      r_tj_off    <= '0;
      r_a_ptr     <= '0;
      r_b_ptr     <= '0;
      r_c_ptr     <= '0;
    end else begin
      r_start_q <= start_i;
      case (r_state)
        S_IDLE: if (w_start_edge) begin
          r_n         <= n_i;
          r_p         <= p_i;
          r_hn        <= n_i << LG;
          r_hp        <= p_i << LG;
          r_mt        <= 16'(w_m_round >> LG);
          r_pt        <= 16'(w_p_round >> LG);
          r_b_base    <= matrix_b_addr_i;
          r_a_tile    <= matrix_a_addr_i;
          r_c_tile    <= matrix_c_addr_i;
          r_tj_off    <= '0;
          r_ti        <= '0;
          r_tj        <= '0;
          r_k         <= '0;
          r_r         <= '0;
          r_zero_wait <= w_zero_dim;
        end
        S_CLEAR: begin
          r_a_ptr <= r_a_tile;
          r_b_ptr <= r_b_base + r_tj_off;
          r_c_ptr <= r_c_tile + r_tj_off;
        end
        S_LOAD_B: if (w_accept) begin
          r_a_ptr <= r_a_ptr + 16'd1;
          r_b_ptr <= r_b_ptr + r_p;
          r_k     <= w_k_last ? 16'd0 : r_k + 16'd1;
        end
        S_STORE: if (w_accept) begin
          r_c_ptr <= r_c_ptr + r_p;
          r_r     <= w_r_last ? '0 : r_r + LG'(1);
          if (w_r_last) begin
            if (w_tj_last) begin
              r_tj     <= '0;
              r_tj_off <= '0;
              r_ti     <= r_ti + 16'd1;
              r_a_tile <= r_a_tile + r_hn;
              r_c_tile <= r_c_tile + r_hp;
            end else begin
              r_tj     <= r_tj + 16'd1;
              r_tj_off <= r_tj_off + H16;
            end
          end
        end
        S_DONE:  r_zero_wait <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] r_cycles;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n)                               r_cycles <= '0;
    else if (r_state == S_IDLE && w_start_edge)  r_cycles <= '0;
    else if (busy_o && r_cycles != 32'hFFFF_FFFF) r_cycles <= r_cycles + 32'd1;
  end

  assign cycles_o = r_cycles;
`else
  assign cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: directed jobs plus randomized jobs against a loop-nest command model.
module tb_matmul_sequencer;
  localparam int H = 16;

  logic        pclk = 1'b0;
  logic        preset_n, start_i, cmd_ready_i, array_busy_i;
  logic [15:0] a_addr, b_addr, c_addr, m_in, n_in, p_in;
  logic        cmd_valid_o, acc_clear_o, busy_o, end_o;
  logic [1:0]  cmd_op_o;
  logic [15:0] cmd_addr_o, cmd_stride_o;
  logic [31:0] cycles_o;

  matmul_sequencer #(.ARRAY_HEIGHT(H)) dut (
    .pclk(pclk), .preset_n(preset_n), .start_i(start_i),
    .matrix_a_addr_i(a_addr), .matrix_b_addr_i(b_addr), .matrix_c_addr_i(c_addr),
    .m_i(m_in), .n_i(n_in), .p_i(p_in),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_op_o(cmd_op_o),
    .cmd_addr_o(cmd_addr_o), .cmd_stride_o(cmd_stride_o), .acc_clear_o(acc_clear_o),
    .array_busy_i(array_busy_i), .busy_o(busy_o), .end_o(end_o), .cycles_o(cycles_o)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  logic [1:0]  exp_op[$];
  logic [15:0] exp_addr[$], exp_stride[$];
  bit          exp_gap[$];
  logic [1:0]  obs_op[$];
  logic [15:0] obs_addr[$];
  int          exp_tiles;
  bit          exp_zero;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: C tiles ti (outer) x tj (inner); per tile N load pairs then H row stores.
  task automatic build_model(input logic [15:0] a, b, c, m, n, p);
    longint mt, pt;
    exp_op.delete(); exp_addr.delete(); exp_stride.delete(); exp_gap.delete();
    exp_zero  = (m == 0) || (n == 0) || (p == 0);
    mt        = (longint'(m) + H - 1) / H;
    pt        = (longint'(p) + H - 1) / H;
    exp_tiles = exp_zero ? 0 : int'(mt * pt);
    if (!exp_zero) begin
      for (longint ti = 0; ti < mt; ti++)
        for (longint tj = 0; tj < pt; tj++) begin
          for (longint k = 0; k < n; k++) begin
            exp_op.push_back(2'd0);
            exp_addr.push_back(16'(longint'(a) + ti * H * n + k));
            exp_stride.push_back(n);
            exp_gap.push_back(1'b0);
            exp_op.push_back(2'd1);
            exp_addr.push_back(16'(longint'(b) + k * p + tj * H));
            exp_stride.push_back(16'd1);
            exp_gap.push_back(k == n - 1);
          end
          for (longint r = 0; r < H; r++) begin
            exp_op.push_back(2'd2);
            exp_addr.push_back(16'(longint'(c) + (ti * H + r) * p + tj * H));
            exp_stride.push_back(16'd1);
            exp_gap.push_back(1'b0);
          end
        end
    end
  endtask

  // mode 0: start pulse, 1: start held high throughout, 2: extra start edge mid-job
  task automatic run_job(input logic [15:0] a, b, c, m, n, p, input int mode, input bit rnd);
    int idx = 0, ends = 0, clears = 0, busy_cnt = 0, end_cyc = -1, last_acc = -1, fall = -1;
    bit stalled = 0, gap_pend = 0, done = 0, relaunch = 0;
    build_model(a, b, c, m, n, p);
    obs_op.delete(); obs_addr.delete();
    @(negedge pclk);
    start_i = 1'b0; cmd_ready_i = 1'b0; array_busy_i = 1'b0;
    a_addr = a; b_addr = b; c_addr = c; m_in = m; n_in = n; p_in = p;
    @(negedge pclk);
    start_i = 1'b1;
    for (int cyc = 1; cyc <= 20000 && !done; cyc++) begin
      @(negedge pclk);
      if (cyc == 1) begin
        chk("busy_t1", busy_o, 1);
        chk("clear_t1", acc_clear_o, exp_zero ? 0 : 1);
        a_addr = 16'($urandom); b_addr = 16'($urandom); c_addr = 16'($urandom);
        m_in = 16'($urandom); n_in = 16'($urandom); p_in = 16'($urandom);
      end
      if (cyc == 2 && !exp_zero) chk("load_a_t2", {cmd_valid_o, cmd_op_o}, {1'b1, 2'd0});
      if (mode == 0 && cyc == 2) start_i = 1'b0;
      if (mode == 2 && cyc == 3) start_i = 1'b0;
      if (mode == 2 && cyc == 6) start_i = 1'b1;
      if (busy_o) busy_cnt++;
      if (acc_clear_o) clears++;
      if (gap_pend) begin
        chk("drain_gap", cmd_valid_o, 0);
        gap_pend = 0;
      end
      if (stalled) chk("valid_held", cmd_valid_o, 1);
      if (cmd_valid_o) begin
        if (idx < exp_op.size()) begin
          chk("cmd_op", cmd_op_o, exp_op[idx]);
          chk("cmd_addr", cmd_addr_o, exp_addr[idx]);
          chk("cmd_stride", cmd_stride_o, exp_stride[idx]);
        end else begin
          chk("extra_cmd", idx, exp_op.size());
        end
      end
      cmd_ready_i  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      array_busy_i = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (cmd_valid_o && cmd_ready_i) begin
        obs_op.push_back(cmd_op_o);
        obs_addr.push_back(cmd_addr_o);
        if (idx < exp_gap.size()) gap_pend = exp_gap[idx];
        idx++;
        last_acc = cyc;
        stalled  = 0;
      end else begin
        stalled = cmd_valid_o;
      end
      if (end_o) begin
        ends++;
        end_cyc = cyc;
      end
      if (!busy_o) begin
        fall = cyc;
        done = 1;
      end
    end
    cmd_ready_i = 1'b0; array_busy_i = 1'b0;
    chk("job_terminated", done, 1);
    chk("cmd_count", idx, exp_op.size());
    chk("end_pulses", ends, 1);
    chk("acc_clears", clears, exp_tiles);
    if (exp_zero) chk("zero_end_cycle", end_cyc, 2);
    else          chk("end_after_last_store", end_cyc, last_acc + 1);
    chk("busy_fall", fall, end_cyc + 1);
`ifdef MATMUL_SEQ_PERF_EN
    chk("cycles_count", cycles_o, busy_cnt);
`else
    chk("cycles_tied", cycles_o, 0);
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      if (busy_o || cmd_valid_o) relaunch = 1;
    end
    chk("no_relaunch", relaunch, 0);
    start_i = 1'b0;
  endtask

  initial begin
    int  nb;
    bit  found;
    preset_n = 1'b0; start_i = 1'b0; cmd_ready_i = 1'b0; array_busy_i = 1'b0;
    a_addr = '0; b_addr = '0; c_addr = '0; m_in = '0; n_in = '0; p_in = '0;
    repeat (3) @(negedge pclk);
    chk("rst_valid", cmd_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_end", end_o, 0);
    chk("rst_clear", acc_clear_o, 0);
    chk("rst_cycles", cycles_o, 0);
    preset_n = 1'b1;

    run_job(16'h1000, 16'h2000, 16'h3000, 16'd32, 16'd32, 16'd32, 0, 1'b0);
    chk("total_cmds", obs_op.size(), 320);
    chk("c0_op", obs_op[0], 2'd0);  chk("c0_addr", obs_addr[0], 16'h1000);
    chk("c1_op", obs_op[1], 2'd1);  chk("c1_addr", obs_addr[1], 16'h2000);
    chk("c2_op", obs_op[2], 2'd0);  chk("c2_addr", obs_addr[2], 16'h1001);
    chk("c3_op", obs_op[3], 2'd1);  chk("c3_addr", obs_addr[3], 16'h2020);
    chk("st0_addr", obs_addr[64], 16'h3000);
    chk("st1_addr", obs_addr[65], 16'h3020);
    chk("tile1_b_op", obs_op[81], 2'd1);
    chk("tile1_b_addr", obs_addr[81], 16'h2010);

    run_job(16'h1000, 16'h2000, 16'h3000, 16'd32, 16'd32, 16'd32, 0, 1'b1);
    run_job(16'h1000, 16'h2000, 16'h3000, 16'd32, 16'd0, 16'd32, 0, 1'b0);
    run_job(16'h0100, 16'h0200, 16'h0300, 16'd16, 16'd4, 16'd16, 1, 1'b0);
    run_job(16'h0400, 16'h0500, 16'h0600, 16'd20, 16'd3, 16'd17, 0, 1'b0);

    run_job(16'hFFF0, 16'h2000, 16'h3000, 16'd16, 16'd32, 16'd16, 0, 1'b0);
    chk("a_wrap_op", obs_op[32], 2'd0);
    chk("a_wrap_addr", obs_addr[32], 16'h0000);

    for (int j = 0; j < 4; j++)
      run_job(16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom_range(1, 40)), 16'($urandom_range(1, 12)),
              16'($urandom_range(1, 40)), (j == 1) ? 2 : 0, 1'b1);

    // Abort a job while a LOAD_B is pending, then restart from scratch.
    @(negedge pclk);
    a_addr = 16'h1000; b_addr = 16'h2000; c_addr = 16'h3000;
    m_in = 16'd32; n_in = 16'd32; p_in = 16'd32;
    start_i = 1'b1; cmd_ready_i = 1'b1;
    nb = 0; found = 0;
    for (int cyc = 0; cyc < 200 && !found; cyc++) begin
      @(negedge pclk);
      if (cmd_valid_o && cmd_op_o == 2'd1) begin
        if (nb >= 2) found = 1;
        else nb++;
      end
    end
    chk("reached_load_b", found, 1);
    preset_n = 1'b0;
    #1;
    chk("midrst_valid", cmd_valid_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_clear", acc_clear_o, 0);
    chk("midrst_end", end_o, 0);
    chk("midrst_cycles", cycles_o, 0);
    start_i = 1'b0;
    repeat (2) @(negedge pclk);
    chk("midrst_hold_valid", cmd_valid_o, 0);
    preset_n = 1'b1;
    run_job(16'h0040, 16'h0080, 16'h00C0, 16'd16, 16'd2, 16'd16, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Sequencer that turns a matrix-multiply job from the APB register block into a stream of tile commands for the ARRAY_HEIGHT x ARRAY_HEIGHT multiply array. C is walked in H x H tiles. For each tile it clears the accumulators, issues N paired A-column/B-row load commands, waits for the array to drain, then issues H row-store commands. It raises a one-cycle end pulse that the register block uses to set the end flag.

## Interface
Parameters:
- ARRAY_HEIGHT, 16, array edge H; power of two, ≥ 2

Ports:
- pclk  in  1  clock, rising edge
- preset_n  in  1  asynchronous active-low reset
- start_i  in  1  start flag from the register block, level
- matrix_a_addr_i / matrix_b_addr_i / matrix_c_addr_i  in  16  base word addresses of A, B, C
- m_i / n_i / p_i  in  16  dimensions: A is MxN, B is NxP, C is MxP
- cmd_valid_o  out  1  command valid
- cmd_ready_i  in  1  command accepted when valid & ready
- cmd_op_o  out  2  0 = LOAD_A, 1 = LOAD_B, 2 = STORE_C
- cmd_addr_o  out  16  first element address
- cmd_stride_o  out  16  address step between the H elements
- acc_clear_o  out  1  one-cycle accumulator clear
- array_busy_i  in  1  array still computing or draining
- busy_o  out  1  job in progress
- end_o  out  1  one-cycle job-complete pulse
- cycles_o  out  32  job cycle count (see Configuration)

## Operation
- States: IDLE, CLEAR, LOAD_A, LOAD_B, DRAIN, STORE, DONE.
- IDLE: waits for a start_i rising edge, registered as start_i & ~start_q. A level held high never relaunches. On the edge: latch the bases, M, N and P; zero ti, tj, k and r.
- Launch routing:
  - Any latched dimension zero: IDLE→DONE.
  - Otherwise: IDLE→CLEAR.
- CLEAR: acc_clear_o=1 for one cycle, then →LOAD_A.
- LOAD_A: addr = A + ti·H·N + k, stride = N. On accept →LOAD_B.
- LOAD_B: addr = B + k·P + tj·H, stride = 1. On accept:
  - k++, then →LOAD_A.
  - If k == N-1: k=0, →DRAIN instead.
- DRAIN: stays while array_busy_i=1. Minimum one cycle, then →STORE.
- STORE: addr = C + (ti·H + r)·P + tj·H, stride = 1. On accept r++. After r == H-1: r=0, then:
  - Tile done, more tiles remain: →CLEAR.
  - Last tile: →DONE.
- Tile order: tj is the inner loop (0..⌈P/H⌉-1), ti is the outer loop (0..⌈M/H⌉-1).
- DONE: end_o=1 for one cycle, then →IDLE.
- Arithmetic:
  - All addresses are modulo 2^16; wrap-around is silent.
  - Address terms are formed with running-pointer adders, not multipliers:
    - A tile pointer advances by H·N per ti.
    - B row pointer advances by P per k.
    - C row pointer advances by P per r.
  - M and P that are not multiples of H are rounded up to whole tiles. Tile-edge masking belongs to the memory side.
- Input changes on m_i..matrix_c_addr_i after launch have no effect until the next launch.
- busy_o=1 in every state except IDLE.

## Timing
- Reset values (also the values for preset_n low at any time, including mid-job): state IDLE, cmd_valid_o 0, acc_clear_o 0, busy_o 0, end_o 0, cycles_o 0, all counters 0.
  - A mid-job reset drops cmd_valid_o immediately. No command or end pulse is issued afterwards.
- Start edge at cycle t gives:
  - busy_o=1 and acc_clear_o=1 in t+1.
  - First LOAD_A valid in t+2.
- Command handshake:
  - cmd_valid_o, once high, holds with cmd_op_o, cmd_addr_o and cmd_stride_o stable until accepted.
  - cmd_valid_o is registered and never depends combinationally on cmd_ready_i.
  - With cmd_ready_i held high, commands are accepted back-to-back, one per cycle.
- end_o rises the cycle after the last STORE accept. busy_o falls one cycle later.
- A start edge during non-IDLE is ignored and is not queued.

## Configuration
- MATMUL_SEQ_PERF_EN defined:
  - cycles_o clears on the launch edge.
  - It increments every cycle while busy_o=1 and holds its value after end_o.
  - It saturates at 0xFFFF_FFFF.
- MATMUL_SEQ_PERF_EN undefined: cycles_o is tied to 0 and no counter is built.

## Test plan
- H=16, A=0x1000, B=0x2000, C=0x3000, M=N=P=32, ready always high:
  - 320 commands total.
  - First four commands: LOAD_A 0x1000/32, LOAD_B 0x2000/1, LOAD_A 0x1001/32, LOAD_B 0x2020/1.
  - First stores: 0x3000, 0x3020.
  - Second tile starts with LOAD_B 0x2010.
  - end_o is a single pulse.
- Same job with cmd_ready_i toggling pseudo-randomly → identical command sequence, payload stable while stalled, no dropped or duplicated commands.
- N=0, start edge → end_o pulses at t+2, no cmd_valid_o, no acc_clear_o.
- start_i held high across and after end_o → exactly one job. Drop and re-raise start_i → second job runs.
- preset_n asserted mid-LOAD_B → all outputs return to reset values that cycle. A fresh start after release restarts from tile (0,0).
- A=0xFFF0, N=32, with MATMUL_SEQ_PERF_EN defined:
  - The LOAD_A address wraps to 0x0000 at k=16.
  - cycles_o equals the measured start-to-end cycle count.
